// File: rtl/mac_tcnt7_if.sv
// Signal bundle for mac_tcnt7. The master drives the load/enable controls
// and the slave (the counter) returns Q, TCL, IRQL and RUN.
// The PRE field exists only when MACTCNT7_PRESCALE_EN is defined.
interface mac_tcnt7_if;
  // No valid/ready pairing: LD, EN and ONESHOT are level strobes sampled on every rising CLK.
  logic       LD;
  logic [6:0] DIN;
  logic       EN;
  logic       ONESHOT;
  logic [6:0] Q;
  logic       TCL;
  logic       IRQL;
  logic       RUN;
`ifdef MACTCNT7_PRESCALE_EN
  logic [3:0] PRE;

  modport master (output LD, DIN, EN, ONESHOT, PRE, input Q, TCL, IRQL, RUN);
  modport slave  (input LD, DIN, EN, ONESHOT, PRE, output Q, TCL, IRQL, RUN);
`else
  modport master (output LD, DIN, EN, ONESHOT, input Q, TCL, IRQL, RUN);
  modport slave  (input LD, DIN, EN, ONESHOT, output Q, TCL, IRQL, RUN);
`endif
endinterface

// File: rtl/mac_tcnt7.sv
// Loadable 7-bit up-counter with auto-reload, combinational active-low terminal
// count and a registered IRQ_LEN-cycle wrap pulse. Optional prescaler: MACTCNT7_PRESCALE_EN.
module mac_tcnt7 #(
  parameter logic [6:0] RST_RELOAD = 7'h00,
  parameter int         IRQ_LEN    = 1
) (
  input  logic      CLK,
  input  logic      RESETL,
  mac_tcnt7_if.slave bus
);

  localparam logic [1:0] IRQ_LAST = 2'(IRQ_LEN - 1);

  logic [6:0] r_q;
  logic [6:0] r_reload;
  logic       r_run;
  logic       r_irql;
  logic [1:0] r_irq_cnt;

  logic       w_en_cyc;
  logic       w_adv;
  logic       w_wrap;

  assign w_en_cyc = r_run & bus.EN;

`ifdef MACTCNT7_PRESCALE_EN
  logic [3:0] r_pre;

  // Counter advances only on the enabled cycle that completes a prescale period.
  assign w_adv = w_en_cyc & (r_pre == bus.PRE);

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_pre <= 4'h0;
    end else if (bus.LD) begin
      r_pre <= 4'h0;
    end else if (w_en_cyc) begin
      r_pre <= w_adv ? 4'h0 : r_pre + 4'h1;
    end
  end
`else
  assign w_adv = w_en_cyc;
`endif

  assign w_wrap = w_adv & (r_q == 7'h7F);

  // IRQL: r_irq_cnt holds how many further low cycles remain after the current one.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_q       <= RST_RELOAD;
      r_reload  <= RST_RELOAD;
      r_run     <= 1'b0;
      r_irql    <= 1'b1;
      r_irq_cnt <= 2'd0;
    end else if (bus.LD) begin
      r_q       <= bus.DIN;
      r_reload  <= bus.DIN;
      r_run     <= 1'b1;
      r_irql    <= 1'b1;
      r_irq_cnt <= 2'd0;
    end else if (w_wrap) begin
      r_q       <= r_reload;
      r_run     <= ~bus.ONESHOT;
      r_irql    <= 1'b0;
      r_irq_cnt <= IRQ_LAST;
    end else begin
      if (w_adv) begin
        r_q <= r_q + 7'd1;
      end
      if (!r_irql) begin
        if (r_irq_cnt == 2'd0) begin
          r_irql <= 1'b1;
        end else begin
          r_irq_cnt <= r_irq_cnt - 2'd1;
        end
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.TCL  = ~w_wrap;
  assign bus.IRQL = r_irql;
  assign bus.RUN  = r_run;

endmodule

// File: tb/tb_mac_tcnt7.sv
// Self-checking bench for mac_tcnt7: two instances (IRQ_LEN 1 and 2) share stimulus
// and are compared against a cycle-level reference model plus directed expectations.
module tb_mac_tcnt7;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESETL = 1'b0;
  always #5 CLK = ~CLK;

  logic       ld = 1'b0;
  logic [6:0] din = 7'h00;
  logic       en = 1'b0;
  logic       oneshot = 1'b0;
  logic [3:0] pre = 4'h0;

  mac_tcnt7_if if0 ();
  mac_tcnt7_if if1 ();

  assign if0.LD = ld;  assign if0.DIN = din;  assign if0.EN = en;  assign if0.ONESHOT = oneshot;
  assign if1.LD = ld;  assign if1.DIN = din;  assign if1.EN = en;  assign if1.ONESHOT = oneshot;
`ifdef MACTCNT7_PRESCALE_EN
  assign if0.PRE = pre;
  assign if1.PRE = pre;
`endif

  mac_tcnt7 #(.RST_RELOAD(7'h00), .IRQ_LEN(1)) dut0 (.CLK(CLK), .RESETL(RESETL), .bus(if0));
  mac_tcnt7 #(.RST_RELOAD(7'h15), .IRQ_LEN(2)) dut1 (.CLK(CLK), .RESETL(RESETL), .bus(if1));

  logic [6:0] obs_q[2];
  logic       obs_tcl[2];
  logic       obs_irql[2];
  logic       obs_run[2];
  assign obs_q[0] = if0.Q;  assign obs_tcl[0] = if0.TCL;  assign obs_irql[0] = if0.IRQL;  assign obs_run[0] = if0.RUN;
  assign obs_q[1] = if1.Q;  assign obs_tcl[1] = if1.TCL;  assign obs_irql[1] = if1.IRQL;  assign obs_run[1] = if1.RUN;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference model ----------------
  int         p_len[2] = '{1, 2};
  logic [6:0] p_rst[2] = '{7'h00, 7'h15};

  logic [6:0] m_q[2];
  logic [6:0] m_reload[2];
  bit         m_run[2];
  int         m_irq_left[2];  // cycles of low IRQL still owed, including the current one
  logic [3:0] m_pre[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = p_rst[k]; m_reload[k] = p_rst[k]; m_run[k] = 1'b0;
      m_irq_left[k] = 0; m_pre[k] = 4'h0;
    end
  endtask

  task automatic model_step(input int k);
    bit en_cyc, tk, wrap;
    en_cyc = m_run[k] && en;
    tk     = en_cyc && (m_pre[k] == pre);
    wrap   = tk && (m_q[k] == 7'h7F);
    if (ld) begin
      m_q[k] = din; m_reload[k] = din; m_run[k] = 1'b1; m_irq_left[k] = 0; m_pre[k] = 4'h0;
    end else begin
      if (en_cyc) m_pre[k] = tk ? 4'h0 : m_pre[k] + 4'h1;
      if (m_irq_left[k] > 0) m_irq_left[k] = m_irq_left[k] - 1;
      if (wrap) begin
        m_q[k] = m_reload[k]; m_run[k] = !oneshot; m_irq_left[k] = p_len[k];
      end else if (tk) begin
        m_q[k] = m_q[k] + 7'd1;
      end
    end
  endtask

  function automatic logic exp_tcl(input int k);
    return !(m_run[k] && en && (m_q[k] == 7'h7F) && (m_pre[k] == pre));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    if (RESETL) begin
      model_step(0);
      model_step(1);
    end
    @(negedge CLK);
  endtask

  task automatic drive(input logic l, input logic [6:0] d, input logic e, input logic o);
    ld = l; din = d; en = e; oneshot = o;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESETL = 1'b0;
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    #12;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      cmp_cnt++;
      if (obs_q[k] !== p_rst[k] || obs_run[k] !== 1'b0 || obs_irql[k] !== 1'b1 || obs_tcl[k] !== 1'b1) begin
        err_cnt++;
        $display("FAIL reset_state dut%0d got q=%h run=%b irql=%b tcl=%b want q=%h run=0 irql=1 tcl=1",
                 k, obs_q[k], obs_run[k], obs_irql[k], obs_tcl[k], p_rst[k]);
      end
    end
    @(negedge CLK);
    #1 RESETL = 1'b1;
    @(negedge CLK);
  endtask

  logic [6:0] exp_q[$];

  task automatic test_free_run();
    logic [6:0] want;
    exp_q = '{7'h7C, 7'h7D, 7'h7E, 7'h7F, 7'h7C, 7'h7D};
    drive(1'b1, 7'h7C, 1'b1, 1'b0);
    tick();
    ld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      want = exp_q.pop_front();
      cmp_cnt++;
      if (obs_q[0] !== want) begin
        err_cnt++;
        $display("FAIL free_q[%0d] got %h want %h", i, obs_q[0], want);
      end
      cmp_cnt++;
      if (obs_tcl[0] !== (want != 7'h7F)) begin
        err_cnt++;
        $display("FAIL free_tcl[%0d] got %b want %b", i, obs_tcl[0], want != 7'h7F);
      end
      cmp_cnt++;
      if (obs_irql[0] !== (i != 4)) begin
        err_cnt++;
        $display("FAIL free_irql[%0d] got %b want %b", i, obs_irql[0], i != 4);
      end
      tick();
    end
  endtask

  task automatic test_oneshot();
    logic [6:0] wq[5]   = '{7'h7E, 7'h7F, 7'h7E, 7'h7E, 7'h7E};
    logic       wrun[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       wirq[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       wtcl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    drive(1'b1, 7'h7E, 1'b1, 1'b1);
    tick();
    ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp_cnt++;
      if (obs_q[0] !== wq[i] || obs_run[0] !== wrun[i] || obs_irql[0] !== wirq[i] || obs_tcl[0] !== wtcl[i]) begin
        err_cnt++;
        $display("FAIL oneshot[%0d] got q=%h run=%b irql=%b tcl=%b want q=%h run=%b irql=%b tcl=%b",
                 i, obs_q[0], obs_run[0], obs_irql[0], obs_tcl[0], wq[i], wrun[i], wirq[i], wtcl[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap_every_cycle();
    drive(1'b1, 7'h7F, 1'b1, 1'b0);
    tick();
    ld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      cmp_cnt++;
      if (obs_q[1] !== 7'h7F || obs_tcl[1] !== 1'b0) begin
        err_cnt++;
        $display("FAIL reload7f_q_tcl[%0d] got q=%h tcl=%b want q=7f tcl=0", i, obs_q[1], obs_tcl[1]);
      end
      for (int k = 0; k < 2; k++) begin
        cmp_cnt++;
        if (obs_irql[k] !== (i == 0)) begin
          err_cnt++;
          $display("FAIL reload7f_irql dut%0d[%0d] got %b want %b", k, i, obs_irql[k], i == 0);
        end
      end
      tick();
    end
  endtask

  task automatic test_ld_over_wrap();
    drive(1'b1, 7'h7F, 1'b1, 1'b0);
    tick();
    drive(1'b1, 7'h10, 1'b1, 1'b0);
    #1;
    cmp_cnt++;
    if (obs_tcl[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL ldwrap_tcl got %b want 0", obs_tcl[0]);
    end
    tick();
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      cmp_cnt++;
      if (obs_q[0] !== 7'h10 || obs_irql[0] !== 1'b1) begin
        err_cnt++;
        $display("FAIL ldwrap[%0d] got q=%h irql=%b want q=10 irql=1", i, obs_q[0], obs_irql[0]);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    int guard;
    drive(1'b1, 7'h55, 1'b1, 1'b0);
    tick();
    ld = 1'b0;
    guard = 0;
    while (m_q[0] != 7'h7F && guard < 200) begin
      tick();
      guard++;
    end
    cmp_cnt++;
    if (guard >= 200) begin
      err_cnt++;
      $display("FAIL areset_reach7f got %h want 7f", m_q[0]);
    end
    tick();
    #1;
    cmp_cnt++;
    if (obs_q[0] !== 7'h55 || obs_irql[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_pre got q=%h irql=%b want q=55 irql=0", obs_q[0], obs_irql[0]);
    end
    RESETL = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      cmp_cnt++;
      if (obs_q[k] !== p_rst[k] || obs_run[k] !== 1'b0 || obs_irql[k] !== 1'b1) begin
        err_cnt++;
        $display("FAIL areset_now dut%0d got q=%h run=%b irql=%b want q=%h run=0 irql=1",
                 k, obs_q[k], obs_run[k], obs_irql[k], p_rst[k]);
      end
    end
    #2 RESETL = 1'b1;
    model_reset();
    tick();
    #1;
    cmp_cnt++;
    if (obs_q[0] !== 7'h00 || obs_run[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_hold got q=%h run=%b want q=00 run=0", obs_q[0], obs_run[0]);
    end
    tick();
  endtask

`ifdef MACTCNT7_PRESCALE_EN
  task automatic test_prescale();
    logic [6:0] wq[7] = '{7'h7E, 7'h7E, 7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7E};
    pre = 4'h2;
    drive(1'b1, 7'h7E, 1'b1, 1'b0);
    tick();
    ld = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      cmp_cnt++;
      if (obs_q[0] !== wq[i] || obs_tcl[0] !== (i != 5)) begin
        err_cnt++;
        $display("FAIL prescale[%0d] got q=%h tcl=%b want q=%h tcl=%b", i, obs_q[0], obs_tcl[0], wq[i], i != 5);
      end
      tick();
    end
    pre = 4'h0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      ld      = ($urandom_range(0, 15) == 0);
      din     = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(112, 127));
      en      = ($urandom_range(0, 3) != 0);
      oneshot = ($urandom_range(0, 5) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        cmp_cnt++;
        if (obs_q[k] !== m_q[k] || obs_run[k] !== m_run[k] ||
            obs_irql[k] !== (m_irq_left[k] == 0) || obs_tcl[k] !== exp_tcl(k)) begin
          err_cnt++;
          $display("FAIL random dut%0d cyc %0d got q=%h run=%b irql=%b tcl=%b want q=%h run=%b irql=%b tcl=%b",
                   k, n, obs_q[k], obs_run[k], obs_irql[k], obs_tcl[k],
                   m_q[k], m_run[k], m_irq_left[k] == 0, exp_tcl(k));
        end
      end
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_oneshot();
    test_wrap_every_cycle();
    test_ld_over_wrap();
    test_async_reset();
`ifdef MACTCNT7_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    if (err_cnt == 0) $display("*** PASS ***");
    else              $display("*** FAIL ***");
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
